// File: rtl/gb_mmu_bus_router.sv
`default_nettype none
// ============================================================================
// Module   : gb_mmu_bus_router
// Desc     : Registered CPU bus router for the GB memory map. It decodes each
//            access to one of eight regions, translates the address to a
//            region offset, and applies wait states, OAM-DMA lockout and an
//            ack timeout. GB_MMU_CGB_BANKING_EN adds the VBK/SVBK bank regs.
// Revision : 1.0 - initial release
// ============================================================================
module gb_mmu_bus_router #(
    parameter int          NUM_REGIONS = 8,
    parameter logic [31:0] WAIT_CYCLES = 32'h0,
    parameter int          TIMEOUT     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [15:0]              cpu_addr,
    input  logic [7:0]               cpu_wdata,
    output logic                     cpu_ready,
    output logic [7:0]               cpu_rdata,
    input  logic                     dma_active,
    output logic [NUM_REGIONS-1:0]   rgn_sel,
    output logic [15:0]              rgn_addr,
    output logic                     rgn_we,
    output logic [7:0]               rgn_wdata,
    input  logic [8*NUM_REGIONS-1:0] rgn_rdata,
    input  logic [NUM_REGIONS-1:0]   rgn_ack,
    output logic                     vram_bank,
    output logic [2:0]               wram_bank
);

    localparam int RW = $clog2(NUM_REGIONS);

    localparam logic [NUM_REGIONS-1:0] c_sel_one   = NUM_REGIONS'(1);
    localparam logic [7:0]             c_tmo_last  = 8'(TIMEOUT - 1);
    localparam logic [1:0]             c_kind_ext  = 2'd0;
    localparam logic [1:0]             c_kind_dead = 2'd1;
`ifdef GB_MMU_CGB_BANKING_EN
    localparam logic [1:0]             c_kind_vbk  = 2'd2;
    localparam logic [1:0]             c_kind_svbk = 2'd3;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state;
    logic [RW-1:0] r_rgn;
    logic [1:0]    r_kind;
    logic [3:0]    r_wait;
    logic [7:0]    r_tmo;

    logic [RW-1:0] w_rgn;
    logic [15:0]   w_base;
    logic [15:0]   w_off;
    logic [1:0]    w_kind;
    logic          w_hram;
    logic          w_ack;
    logic [7:0]    w_ack_data;
    logic [7:0]    w_int_rdata;

    // Address decode: region index, region base and access kind
    always_comb begin
        w_rgn  = RW'(0);
        w_base = 16'h0000;
        w_kind = c_kind_ext;
        if (!cpu_addr[15]) begin
            w_rgn  = RW'(0);
            w_base = 16'h0000;
        end else if (cpu_addr[15:13] == 3'b100) begin
            w_rgn  = RW'(1);
            w_base = 16'h8000;
        end else if (cpu_addr[15:13] == 3'b101) begin
            w_rgn  = RW'(2);
            w_base = 16'hA000;
        end else if (cpu_addr[15:13] == 3'b110) begin
            w_rgn  = RW'(3);
            w_base = 16'hC000;
        end else if (cpu_addr < 16'hFE00) begin
            w_rgn  = RW'(3);
            w_base = 16'hE000;
        end else if (cpu_addr < 16'hFEA0) begin
            w_rgn  = RW'(4);
            w_base = 16'hFE00;
        end else if (cpu_addr < 16'hFF00) begin
            w_kind = c_kind_dead;
        end else if (cpu_addr < 16'hFF80) begin
            w_rgn  = RW'(5);
            w_base = 16'hFF00;
        end else if (cpu_addr != 16'hFFFF) begin
            w_rgn  = RW'(6);
            w_base = 16'hFF80;
        end else begin
            w_rgn  = RW'(7);
            w_base = 16'hFFFF;
        end
`ifdef GB_MMU_CGB_BANKING_EN
        if (cpu_addr == 16'hFF4F) begin
            w_kind = c_kind_vbk;
        end
        if (cpu_addr == 16'hFF70) begin
            w_kind = c_kind_svbk;
        end
`endif
        // During OAM DMA only HRAM stays reachable
        w_hram = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
        if (dma_active && !w_hram) begin
            w_kind = c_kind_dead;
        end
    end

    assign w_off      = cpu_addr - w_base;
    assign w_ack      = rgn_ack[r_rgn];
    assign w_ack_data = rgn_rdata[8*r_rgn +: 8];

    always_comb begin
        w_int_rdata = 8'hFF;
`ifdef GB_MMU_CGB_BANKING_EN
        if (r_kind == c_kind_vbk) begin
            w_int_rdata = {7'h7F, vram_bank};
        end else if (r_kind == c_kind_svbk) begin
            w_int_rdata = {5'h1F, wram_bank};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rgn     <= RW'(0);
            r_kind    <= c_kind_ext;
            r_wait    <= 4'd0;
            r_tmo     <= 8'd0;
            cpu_ready <= 1'b0;
            cpu_rdata <= 8'hFF;
            rgn_sel   <= '0;
            rgn_addr  <= 16'h0000;
            rgn_we    <= 1'b0;
            rgn_wdata <= 8'h00;
`ifdef GB_MMU_CGB_BANKING_EN
            vram_bank <= 1'b0;
            wram_bank <= 3'd1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    cpu_ready <= 1'b0;
                    if (cpu_req) begin
                        r_rgn     <= w_rgn;
                        r_kind    <= w_kind;
                        r_tmo     <= 8'd0;
                        rgn_addr  <= w_off;
                        rgn_we    <= cpu_we;
                        rgn_wdata <= cpu_wdata;
                        if (w_kind == c_kind_ext) begin
                            rgn_sel <= c_sel_one << w_rgn;
                            r_wait  <= WAIT_CYCLES[4*w_rgn +: 4];
                        end else begin
                            rgn_sel <= '0;
                            r_wait  <= 4'd0;
                        end
                        r_state <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    r_tmo <= r_tmo + 8'd1;
                    if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end
                    if (r_kind != c_kind_ext) begin
                        cpu_rdata <= w_int_rdata;
                        cpu_ready <= 1'b1;
                        rgn_sel   <= '0;
                        r_state   <= S_DONE;
`ifdef GB_MMU_CGB_BANKING_EN
                        if (rgn_we && (r_kind == c_kind_vbk)) begin
                            vram_bank <= rgn_wdata[0];
                        end
                        if (rgn_we && (r_kind == c_kind_svbk)) begin
                            wram_bank <= (rgn_wdata[2:0] == 3'd0) ? 3'd1 : rgn_wdata[2:0];
                        end
`endif
                    end else if ((r_wait == 4'd0) && w_ack) begin
                        cpu_rdata <= w_ack_data;
                        cpu_ready <= 1'b1;
                        rgn_sel   <= '0;
                        r_state   <= S_DONE;
                    end else if (r_tmo == c_tmo_last) begin
                        // Target never answered: complete as open bus
                        cpu_rdata <= 8'hFF;
                        cpu_ready <= 1'b1;
                        rgn_sel   <= '0;
                        r_state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    cpu_ready <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef GB_MMU_CGB_BANKING_EN
    assign vram_bank = 1'b0;
    assign wram_bank = 3'd1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gb_mmu_bus_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_mmu_bus_router
// Desc     : Randomized scoreboard bench for gb_mmu_bus_router with a
//            memory-map reference model; honours GB_MMU_CGB_BANKING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_mmu_bus_router;

    localparam int          NR    = 8;
    localparam logic [31:0] WAITS = 32'h2010_3210;
    localparam int          TMO   = 16;
    localparam int          NEVER = 1000;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              cpu_req    = 1'b0;
    logic              cpu_we     = 1'b0;
    logic [15:0]       cpu_addr   = 16'h0000;
    logic [7:0]        cpu_wdata  = 8'h00;
    logic              dma_active = 1'b0;
    logic [8*NR-1:0]   rgn_rdata  = '0;
    logic [NR-1:0]     rgn_ack    = '0;
    logic              cpu_ready;
    logic [7:0]        cpu_rdata;
    logic [NR-1:0]     rgn_sel;
    logic [15:0]       rgn_addr;
    logic              rgn_we;
    logic [7:0]        rgn_wdata;
    logic              vram_bank;
    logic [2:0]        wram_bank;

    gb_mmu_bus_router #(
        .NUM_REGIONS (NR),
        .WAIT_CYCLES (WAITS),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .dma_active (dma_active),
        .rgn_sel    (rgn_sel),
        .rgn_addr   (rgn_addr),
        .rgn_we     (rgn_we),
        .rgn_wdata  (rgn_wdata),
        .rgn_rdata  (rgn_rdata),
        .rgn_ack    (rgn_ack),
        .vram_bank  (vram_bank),
        .wram_bank  (wram_bank)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit          internal;
        logic [15:0] addr;
        logic [7:0]  sel;
        logic [15:0] off;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          lat;
        logic        vb;
        logic [2:0]  wb;
    } exp_t;

    exp_t       exp_q[$];
    int         start_q[$];
    int         checks     = 0;
    int         errors     = 0;
    int         cyc        = 0;
    int         ack_delay  = 0;
    int         acnt       = 0;
    int         sel_cycles = 0;
    bit         abort_mode = 1'b0;
    logic       m_vb       = 1'b0;
    logic [2:0] m_wb       = 3'd1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Memory map as a plain address table
    function automatic void ref_decode(input logic [15:0] a, input bit dma,
                                       output int kind, output int rgn, output logic [15:0] off);
        int ia;
        ia   = int'(a);
        kind = 0;
        rgn  = 0;
        off  = a;
        if (ia < 'h8000)      begin rgn = 0; off = a; end
        else if (ia < 'hA000) begin rgn = 1; off = 16'(ia - 'h8000); end
        else if (ia < 'hC000) begin rgn = 2; off = 16'(ia - 'hA000); end
        else if (ia < 'hE000) begin rgn = 3; off = 16'(ia - 'hC000); end
        else if (ia < 'hFE00) begin rgn = 3; off = 16'(ia - 'hE000); end
        else if (ia < 'hFEA0) begin rgn = 4; off = 16'(ia - 'hFE00); end
        else if (ia < 'hFF00) begin kind = 1; end
        else if (ia < 'hFF80) begin rgn = 5; off = 16'(ia - 'hFF00); end
        else if (ia < 'hFFFF) begin rgn = 6; off = 16'(ia - 'hFF80); end
        else                  begin rgn = 7; off = 16'h0000; end
`ifdef GB_MMU_CGB_BANKING_EN
        if (ia == 'hFF4F) kind = 2;
        if (ia == 'hFF70) kind = 3;
`endif
        if (dma && !(ia >= 'hFF80 && ia <= 'hFFFE)) kind = 1;
    endfunction

    function automatic exp_t predict(input bit we, input logic [15:0] a, input logic [7:0] wd,
                                     input bit dma, input int d, input logic [63:0] rd);
        exp_t        e;
        int          kind, rgn, w, k;
        logic [15:0] off;
        ref_decode(a, dma, kind, rgn, off);
        e.we       = we;
        e.addr     = a;
        e.off      = off;
        e.wdata    = wd;
        e.internal = (kind != 0);
        e.sel      = e.internal ? 8'h00 : 8'(1 << rgn);
        if (e.internal) begin
            e.lat   = 1;
            e.rdata = 8'hFF;
            if (kind == 2) begin
                if (we) m_vb = wd[0];
                else    e.rdata = {7'h7F, m_vb};
            end
            if (kind == 3) begin
                if (we) m_wb = (wd[2:0] == 3'd0) ? 3'd1 : wd[2:0];
                else    e.rdata = {5'h1F, m_wb};
            end
        end else begin
            w = int'((WAITS >> (4 * rgn)) & 32'hF);
            k = ((w > d) ? w : d) + 1;
            if (k <= TMO) begin
                e.lat   = k;
                e.rdata = rd[8*rgn +: 8];
            end else begin
                e.lat   = TMO;
                e.rdata = 8'hFF;
            end
        end
        e.vb = m_vb;
        e.wb = m_wb;
        return e;
    endfunction

    // Target side: selected region acks after ack_delay strobe cycles, others chatter
    always @(negedge clk) begin
        if (rgn_sel != '0) begin
            rgn_ack = ((acnt >= ack_delay) ? rgn_sel : 8'h00) | (8'($urandom) & ~rgn_sel);
            acnt++;
        end else begin
            acnt    = 0;
            rgn_ack = 8'($urandom);
        end
    end

    // Monitor: compares strobes and completions against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        int   s;
        if (!reset) begin
            if (rgn_sel != '0 && !abort_mode) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got rgn_sel %0h, expected none", rgn_sel);
                end else begin
                    chk("rgn_sel", 32'(rgn_sel), 32'(exp_q[0].sel));
                    chk("rgn_addr", 32'(rgn_addr), 32'(exp_q[0].off));
                    chk("rgn_we", 32'(rgn_we), 32'(exp_q[0].we));
                    if (exp_q[0].we) chk("rgn_wdata", 32'(rgn_wdata), 32'(exp_q[0].wdata));
                    sel_cycles++;
                end
            end
            if (cpu_ready) begin
                if (abort_mode || exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got cpu_ready 1, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    s = start_q.pop_front();
                    chk("latency", 32'(cyc - s), 32'(e.lat));
                    chk("strobe_cycles", 32'(sel_cycles), e.internal ? 32'd0 : 32'(e.lat));
                    if (!e.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
                    chk("vram_bank", 32'(vram_bank), 32'(e.vb));
                    chk("wram_bank", 32'(wram_bank), 32'(e.wb));
                end
                sel_cycles = 0;
            end
        end
    end

    task automatic do_access(input bit we, input logic [15:0] a, input logic [7:0] wd,
                             input bit dma, input int d, input bit hold, input logic [63:0] rd);
        int n;
        rgn_rdata = rd;
        ack_delay = d;
        exp_q.push_back(predict(we, a, wd, dma, d, rd));
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = a;
        cpu_wdata  = wd;
        dma_active = dma;
        @(posedge clk);
        #1;
        start_q.push_back(cyc);
        dma_active = 1'($urandom_range(0, 1));
        n = 0;
        @(negedge clk);
        while (!cpu_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: no cpu_ready within 100 cycles for addr %04h", a);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        if (hold) @(negedge clk);
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom);
        cpu_addr  = 16'($urandom);
        cpu_wdata = 8'($urandom);
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        case ($urandom_range(0, 11))
            0:  a = 16'($urandom_range('h0000, 'h7FFF));
            1:  a = 16'($urandom_range('h8000, 'h9FFF));
            2:  a = 16'($urandom_range('hA000, 'hBFFF));
            3:  a = 16'($urandom_range('hC000, 'hDFFF));
            4:  a = 16'($urandom_range('hE000, 'hFDFF));
            5:  a = 16'($urandom_range('hFE00, 'hFE9F));
            6:  a = 16'($urandom_range('hFEA0, 'hFEFF));
            7:  a = 16'($urandom_range('hFF00, 'hFF7F));
            8:  a = 16'($urandom_range('hFF80, 'hFFFE));
            9:  a = 16'hFFFF;
            10: a = ($urandom_range(0, 1) != 0) ? 16'hFF4F : 16'hFF70;
            default: a = 16'($urandom);
        endcase
        return a;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("reset_cpu_rdata", 32'(cpu_rdata), 32'hFF);
        chk("reset_rgn_sel", 32'(rgn_sel), 32'd0);
        chk("reset_rgn_addr", 32'(rgn_addr), 32'd0);
        chk("reset_rgn_we", 32'(rgn_we), 32'd0);
        chk("reset_rgn_wdata", 32'(rgn_wdata), 32'd0);
        chk("reset_vram_bank", 32'(vram_bank), 32'd0);
        chk("reset_wram_bank", 32'(wram_bank), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        do_access(1'b0, 16'h0150, 8'h00, 1'b0, 0, 1'b0, 64'h1111_2222_3333_443C);
        do_access(1'b1, 16'hE123, 8'h5A, 1'b0, 0, 1'b0, {$urandom, $urandom});
        do_access(1'b0, 16'hFEA5, 8'h00, 1'b0, 0, 1'b0, {$urandom, $urandom});
        do_access(1'b0, 16'hC000, 8'h00, 1'b1, 0, 1'b0, {$urandom, $urandom});
        do_access(1'b0, 16'hFF90, 8'h00, 1'b1, 0, 1'b0, {$urandom, $urandom});
        do_access(1'b0, 16'h8000, 8'h00, 1'b0, NEVER, 1'b0, {$urandom, $urandom});
        do_access(1'b0, 16'h9ABC, 8'h00, 1'b0, 0, 1'b0, {$urandom, $urandom});
        do_access(1'b1, 16'hFF70, 8'h00, 1'b0, 0, 1'b0, {$urandom, $urandom});
        do_access(1'b1, 16'hFF70, 8'h05, 1'b0, 0, 1'b0, {$urandom, $urandom});
        do_access(1'b0, 16'hFF70, 8'h00, 1'b0, 0, 1'b0, {$urandom, $urandom});
        do_access(1'b1, 16'hFF4F, 8'hFF, 1'b0, 0, 1'b1, {$urandom, $urandom});
        do_access(1'b0, 16'hFF4F, 8'h00, 1'b0, 0, 1'b0, {$urandom, $urandom});

        for (int i = 0; i < 300; i++) begin
            do_access(1'($urandom), rand_addr(), 8'($urandom),
                      ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 6)),
                      ($urandom_range(0, 3) == 0), {$urandom, $urandom});
        end

        // Re-establish a non-default SVBK value, then reset in the middle of an access
        do_access(1'b1, 16'hFF70, 8'h06, 1'b0, 0, 1'b0, {$urandom, $urandom});
        abort_mode = 1'b1;
        ack_delay  = NEVER;
        cpu_req    = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 16'h8000;
        dma_active = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_access_sel", 32'(rgn_sel), 32'h02);
        #2;
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk("abort_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("abort_rgn_sel", 32'(rgn_sel), 32'd0);
        chk("abort_cpu_rdata", 32'(cpu_rdata), 32'hFF);
        chk("abort_vram_bank", 32'(vram_bank), 32'd0);
        chk("abort_wram_bank", 32'(wram_bank), 32'd1);
        m_vb = 1'b0;
        m_wb = 3'd1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_abort_ready", 32'(cpu_ready), 32'd0);
        abort_mode = 1'b0;

        do_access(1'b0, 16'h0150, 8'h00, 1'b0, 0, 1'b0, {$urandom, $urandom});
        do_access(1'b0, 16'hFF70, 8'h00, 1'b0, 0, 1'b0, {$urandom, $urandom});
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
